// File: rtl/dcfifo_wr_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO controller: producer handshake,
// RAM write port, pointer export and the synchronized read pointer.
interface dcfifo_wr_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic                  wrreq;
  logic [PW-1:0]         rd_gray_sync;
  logic                  wren;
  logic [ADDR_WIDTH-1:0] wraddr;
  logic [PW-1:0]         wptr_bin;
  logic                  wrfull;
  logic [PW-1:0]         wrusedw;
  logic                  wr_drop;

  // Producer / environment side
  modport master (
    output wrreq,
    output rd_gray_sync,
    input  wren,
    input  wraddr,
    input  wptr_bin,
    input  wrfull,
    input  wrusedw,
    input  wr_drop
  );

  // Controller side
  modport slave (
    input  wrreq,
    input  rd_gray_sync,
    output wren,
    output wraddr,
    output wptr_bin,
    output wrfull,
    output wrusedw,
    output wr_drop
  );
endinterface

// File: rtl/dcfifo_wr_ctrl.sv
// Write-domain pointer and flag controller for the dual-clock FIFO: accepts
// writes, owns the binary write pointer, and derives full/used from the synced read pointer.
module dcfifo_wr_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic           clock,
  input  logic           aclr_n,
  dcfifo_wr_ctrl_if.slave bus
);
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wptr_next;
  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] rptr_bin_q;
  logic [PW-1:0] used_next;
  logic [PW-1:0] usedw_q;
  logic          full_q;
  logic          drop_q;
  logic          wren_c;

  // Write acceptance depends only on registered full, so no path from the read side
  always_comb begin
    wren_c    = bus.wrreq & ~full_q;
    wptr_next = wptr_q + PW'(wren_c);
  end

  // Gray to binary: bit i is the XOR of all gray bits at or above i
  always_comb begin
    rptr_bin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rptr_bin[i] = ^(bus.rd_gray_sync >> i);
    end
  end

  // Occupancy uses the lagged read pointer, so the count errs on the full side
  always_comb begin
    used_next = wptr_next - rptr_bin_q;
  end

  // Full comes up in reset so nothing is written until the first clean edge
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wptr_q     <= '0;
      rptr_bin_q <= '0;
      usedw_q    <= '0;
      full_q     <= 1'b1;
      drop_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_next;
      rptr_bin_q <= rptr_bin;
      usedw_q    <= used_next;
      full_q     <= (used_next == PW'(DEPTH));
      drop_q     <= bus.wrreq & full_q;
    end
  end

  always_comb begin
    bus.wren     = wren_c;
    bus.wraddr   = wptr_q[ADDR_WIDTH-1:0];
    bus.wptr_bin = wptr_q;
    bus.wrfull   = full_q;
    bus.wrusedw  = usedw_q;
    bus.wr_drop  = drop_q;
  end
endmodule

// File: tb/tb_dcfifo_wr_ctrl.sv
// Directed bench for dcfifo_wr_ctrl at ADDR_WIDTH = 4 (DEPTH 16, 5-bit pointers).
module tb_dcfifo_wr_ctrl;
  localparam int unsigned ADDR_WIDTH = 4;

  logic clock;
  logic aclr_n;
  int   n_checks;
  int   n_pass;

  dcfifo_wr_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  dcfifo_wr_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock  (clock),
    .aclr_n (aclr_n),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    aclr_n   = 1'b0;
    bus.wrreq        = 1'b1;
    bus.rd_gray_sync = 5'b00000;

    // Reset with a pending request
    step();
    step();
    check("rst_wren",    32'(bus.wren),     0);
    check("rst_wrfull",  32'(bus.wrfull),   1);
    check("rst_wptr",    32'(bus.wptr_bin), 0);
    check("rst_usedw",   32'(bus.wrusedw),  0);
    check("rst_drop",    32'(bus.wr_drop),  0);

    aclr_n = 1'b1;
    #1;
    check("rel_wren_pre", 32'(bus.wren), 0);
    step();
    // First edge: full clears; the request seen against full=1 counts as a drop
    check("rel_wrfull",  32'(bus.wrfull),   0);
    check("rel_wptr",    32'(bus.wptr_bin), 0);
    check("rel_drop",    32'(bus.wr_drop),  1);
    check("rel_wren",    32'(bus.wren),     1);

    // Fill: 16 back-to-back writes
    for (int k = 0; k < 16; k++) begin
      check($sformatf("fill_wraddr%0d", k), 32'(bus.wraddr), 32'(k));
      step();
      check($sformatf("fill_usedw%0d", k),  32'(bus.wrusedw), 32'(k + 1));
      check($sformatf("fill_full%0d", k),   32'(bus.wrfull),  (k == 15) ? 32'd1 : 32'd0);
    end
    check("fill_wptr",  32'(bus.wptr_bin), 16);
    check("fill_drop",  32'(bus.wr_drop),  0);

    // Overflow: request held 3 cycles while full
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ovf_wren%0d", k), 32'(bus.wren), 0);
      step();
      check($sformatf("ovf_drop%0d", k), 32'(bus.wr_drop),  1);
      check($sformatf("ovf_wptr%0d", k), 32'(bus.wptr_bin), 16);
    end
    bus.wrreq = 1'b0;
    step();
    check("ovf_drop_end", 32'(bus.wr_drop), 0);

    // Drain visibility: read pointer jumps to 4
    bus.rd_gray_sync = 5'b00110;
    step();
    check("drain_usedw1", 32'(bus.wrusedw), 16);
    check("drain_full1",  32'(bus.wrfull),  1);
    step();
    check("drain_usedw2", 32'(bus.wrusedw), 12);
    check("drain_full2",  32'(bus.wrfull),  0);

    // Move read pointer to 16 (gray 11000): empty from the write side
    bus.rd_gray_sync = 5'b11000;
    step();
    step();
    check("rp16_usedw", 32'(bus.wrusedw), 0);

    // 15 writes take wptr to 31
    bus.wrreq = 1'b1;
    for (int k = 0; k < 15; k++) step();
    bus.wrreq = 1'b0;
    check("pre_wrap_usedw", 32'(bus.wrusedw), 15);

    // Read pointer to 20 (gray 11110): 31 - 20 = 11
    bus.rd_gray_sync = 5'b11110;
    step();
    step();
    check("wrap_wptr_pre",   32'(bus.wptr_bin), 31);
    check("wrap_wraddr_pre", 32'(bus.wraddr),   15);
    check("wrap_usedw_pre",  32'(bus.wrusedw),  11);
    bus.wrreq = 1'b1;
    step();
    bus.wrreq = 1'b0;
    check("wrap_wptr",   32'(bus.wptr_bin), 0);
    check("wrap_wraddr", 32'(bus.wraddr),   0);
    check("wrap_usedw",  32'(bus.wrusedw),  12);

    // Simultaneous write and read advance to 21 (gray 11111)
    bus.wrreq        = 1'b1;
    bus.rd_gray_sync = 5'b11111;
    step();
    bus.wrreq = 1'b0;
    check("sim_usedw1", 32'(bus.wrusedw), 13);
    step();
    check("sim_usedw2", 32'(bus.wrusedw), 12);
    check("sim_wptr",   32'(bus.wptr_bin), 1);

    // Mid-burst asynchronous reset, read side reset in the same event
    bus.wrreq = 1'b1;
    step();
    step();
    check("burst_wptr", 32'(bus.wptr_bin), 3);
    #2;
    aclr_n           = 1'b0;
    bus.rd_gray_sync = 5'b00000;
    #1;
    check("arst_wren",   32'(bus.wren),     0);
    check("arst_wrfull", 32'(bus.wrfull),   1);
    check("arst_wptr",   32'(bus.wptr_bin), 0);
    check("arst_wraddr", 32'(bus.wraddr),   0);
    check("arst_usedw",  32'(bus.wrusedw),  0);
    check("arst_drop",   32'(bus.wr_drop),  0);
    bus.wrreq = 1'b0;
    step();
    aclr_n = 1'b1;
    step();
    check("rearm_full",  32'(bus.wrfull),  0);
    check("rearm_usedw", 32'(bus.wrusedw), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
